mer_meas_ctrl: RTL
==================

Name: mer_meas_ctrl

Overview:
Sequencer for the I/Q MER measurement datapath (LFSR source, DUT pair, slicers, avg_err_squared_55 accumulators, symbol comparators). On start it waits a settle interval, aligns to the LFSR cycle pulse, and runs NUM_WIN measurement windows, each one LFSR period long. Per window it counts symbol errors on I and Q and latches both error-square accumulators. Results go to a SignalTap/ISSP-facing consumer over a valid/ready handshake.

Parameters:
SETTLE_SYMS, 16, symbols to wait after start before alignment (covers DUT and DELAY pipeline fill)
NUM_WIN, 4, measurement windows per run (1..255)
CNT_W, 24, symbol-error counter width
SQ_W, 56, width of err_square inputs and latched results

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sym_clk_en  in  1  symbol-rate enable, one sys_clk wide
cycle  in  1  LFSR period pulse; always coincident with sym_clk_en
start  in  1  begin a run; sampled in IDLE only
abort  in  1  terminate run immediately
sym_err_i  in  1  I-rail symbol error flag, valid on sym_clk_en
sym_err_q  in  1  Q-rail symbol error flag, valid on sym_clk_en
err_square_i  in  SQ_W  I-rail accumulated error square
err_square_q  in  SQ_W  Q-rail accumulated error square
busy  out  1  high in any state other than IDLE
res_valid  out  1  result registers hold an unaccepted window result
res_ready  in  1  consumer accepts the result when res_valid and res_ready are both high
res_sq_i  out  SQ_W  latched err_square_i
res_sq_q  out  SQ_W  latched err_square_q
res_err_cnt  out  CNT_W  I+Q symbol errors in the window
res_win_idx  out  8  window index, 0..NUM_WIN-1
overrun  out  1  sticky; a result was overwritten before it was accepted
done  out  1  one-sys_clk pulse at end of run

Behaviour:
- Reset value of every output and internal register is 0. State on reset is IDLE.
- States: IDLE, SETTLE, ALIGN, MEASURE, DRAIN.
- IDLE: start=1 moves to SETTLE, clears overrun, and loads the settle counter with SETTLE_SYMS. start is ignored in every other state.
- SETTLE: the settle counter decrements on each sym_clk_en. When it reaches 0, move to ALIGN. cycle pulses are ignored in SETTLE.
- ALIGN: the first cycle pulse moves to MEASURE. The error counter is cleared to 0, the window index is cleared to 0, and the errors of that symbol are not counted.
- MEASURE, on each sym_clk_en with cycle=0: the error counter adds sym_err_i + sym_err_q (0..2). The counter saturates at 2^CNT_W-1 and does not wrap.
- MEASURE, on a sym_clk_en with cycle=1 (window close), all on the same edge:
  - res_sq_i/q load err_square_i/q.
  - res_err_cnt loads the counter plus the current symbol's contribution, with saturation.
  - res_win_idx loads the window index, and res_valid is set.
  - The counter restarts at 0 and the window index increments.
  - If this was window NUM_WIN-1, move to DRAIN.
- Handshake: res_valid clears on the edge where res_valid and res_ready are both 1. If a window close and an acceptance occur on the same edge, the new result loads, res_valid stays 1, and overrun is not set. If a window close occurs while res_valid=1 and res_ready=0, the result is overwritten and overrun is set (sticky until the next start).
- Result registers change only on a window close. They are stable while res_valid=1 unless overwritten.
- DRAIN: wait until res_valid=0, with acceptance on the current edge counting as 0. Then pulse done for one cycle and return to IDLE.
- abort=1 from any state, on the next edge:
  - go to IDLE and clear res_valid and all counters;
  - done is not pulsed;
  - result data registers and overrun hold their values.
- abort has priority over start, cycle and res_ready on the same edge.
- Reset asserted mid-run returns everything to reset values immediately (asynchronous).
- Latency: result appears 1 sys_clk after the closing cycle pulse. done appears 1 sys_clk after the final acceptance.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=0, SETTLE=1, ALIGN=2, MEASURE=3, DRAIN=4);
  - the saturating-add helper function;
  - the default SQ_W/CNT_W constants, shared with avg_err_squared_55.
- One natural sub-module: mer_result_reg. It holds the result registers, the valid/ready logic and overrun, which keeps the handshake independently testable.

Test Plan:
1. SETTLE_SYMS=4, NUM_WIN=2, cycle every 16 symbols, no errors, res_ready=1 -> two results with res_err_cnt=0 and res_win_idx=0 then 1, res_sq values equal to the inputs at each pulse, done pulses once, busy falls with done.
2. sym_err_i=1 and sym_err_q=1 on every symbol, 16-symbol window -> res_err_cnt=32. With CNT_W=4 -> res_err_cnt=15 (saturated).
3. res_ready=0 across two window closes -> overrun=1, res_win_idx=1, res_valid=1. DRAIN holds until res_ready=1, then done pulses.
4. res_ready=1 on the same edge as a window close with res_valid=1 -> new result loaded, res_valid stays 1, overrun=0.
5. abort asserted in MEASURE during window 0 -> IDLE next edge, res_valid=0, no done. A subsequent start runs normally from SETTLE.
6. cycle pulse during SETTLE and start pulses while busy -> both ignored. Alignment occurs on the first cycle pulse after settle.

Source files
------------

// File: rtl/mer_meas_ctrl_pkg.sv
// Shared types and helpers for the MER measurement sequencer and the
// avg_err_squared_55 accumulators that feed it.
package mer_meas_ctrl_pkg;

  localparam int DEF_SQ_W  = 56;
  localparam int DEF_CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Add a 0..2 symbol-error increment to a counter of width w, clamping at 2^w-1.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [1:0]  b,
                                          input int          w);
    logic [63:0] max_v;
    logic [64:0] sum;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum   = {1'b0, a} + {63'd0, b};
    if (sum > {1'b0, max_v})
      return max_v;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/mer_result_reg.sv
// Window result holding registers with valid/ready handoff to the
// SignalTap/ISSP consumer and a sticky overrun flag.
module mer_result_reg
  import mer_meas_ctrl_pkg::*;
#(
  parameter int SQ_W  = DEF_SQ_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             flush,
  input  logic             clear_overrun,
  input  logic [SQ_W-1:0]  sq_i,
  input  logic [SQ_W-1:0]  sq_q,
  input  logic [CNT_W-1:0] err_cnt,
  input  logic [7:0]       win_idx,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [SQ_W-1:0]  res_sq_i,
  output logic [SQ_W-1:0]  res_sq_q,
  output logic [CNT_W-1:0] res_err_cnt,
  output logic [7:0]       res_win_idx,
  output logic             overrun,
  output logic             accept
);

  assign accept = res_valid & res_ready;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      res_sq_i    <= '0;
      res_sq_q    <= '0;
      res_err_cnt <= '0;
      res_win_idx <= '0;
    end else if (load) begin
      res_sq_i    <= sq_i;
      res_sq_q    <= sq_q;
      res_err_cnt <= err_cnt;
      res_win_idx <= win_idx;
    end
  end

  // A load wins over a same-edge acceptance: the new result stays valid.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      res_valid <= 1'b0;
    else if (flush)
      res_valid <= 1'b0;
    else if (load)
      res_valid <= 1'b1;
    else if (accept)
      res_valid <= 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (clear_overrun)
      overrun <= 1'b0;
    else if (load && res_valid && !res_ready)
      overrun <= 1'b1;
  end

endmodule

// File: rtl/mer_meas_ctrl.sv
// Sequencer for the I/Q MER measurement: settle, align to the LFSR period,
// then count symbol errors and latch error squares over NUM_WIN windows.
//
//   state   | meaning
//   IDLE    | waiting for start
//   SETTLE  | counting down SETTLE_SYMS symbols of pipeline fill
//   ALIGN   | waiting for the first LFSR cycle pulse
//   MEASURE | accumulating errors; each cycle pulse closes a window
//   DRAIN   | last result published, waiting for it to be accepted
module mer_meas_ctrl
  import mer_meas_ctrl_pkg::*;
#(
  parameter int SETTLE_SYMS = 16,
  parameter int NUM_WIN     = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SQ_W        = DEF_SQ_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             cycle,
  input  logic             start,
  input  logic             abort,
  input  logic             sym_err_i,
  input  logic             sym_err_q,
  input  logic [SQ_W-1:0]  err_square_i,
  input  logic [SQ_W-1:0]  err_square_q,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SQ_W-1:0]  res_sq_i,
  output logic [SQ_W-1:0]  res_sq_q,
  output logic [CNT_W-1:0] res_err_cnt,
  output logic [7:0]       res_win_idx,
  output logic             overrun,
  output logic             done
);

  localparam int         SET_W    = (SETTLE_SYMS < 2) ? 1 : $clog2(SETTLE_SYMS + 1);
  localparam logic [7:0] LAST_WIN = 8'(NUM_WIN - 1);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         win_q, win_d;
  logic               done_q, done_d;
  logic [1:0]         sym_errs;
  logic [CNT_W-1:0]   cnt_inc;
  logic               close;
  logic               start_go;
  logic               accept;

  assign sym_errs = {1'b0, sym_err_i} + {1'b0, sym_err_q};
  assign cnt_inc  = CNT_W'(sat_add(64'(cnt_q), sym_errs, CNT_W));
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    done_d   = 1'b0;
    close    = 1'b0;
    start_go = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      cnt_d    = '0;
      win_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_SETTLE;
            settle_d = SET_W'(SETTLE_SYMS);
            start_go = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0)
            state_d = ST_ALIGN;
          else if (sym_clk_en)
            settle_d = settle_q - SET_W'(1);
        end
        ST_ALIGN: begin
          // The aligning symbol itself is not part of any window.
          if (sym_clk_en && cycle) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
            win_d   = '0;
          end
        end
        ST_MEASURE: begin
          if (sym_clk_en) begin
            if (cycle) begin
              close = 1'b1;
              cnt_d = '0;
              win_d = win_q + 8'd1;
              if (win_q == LAST_WIN)
                state_d = ST_DRAIN;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_DRAIN: begin
          if (!res_valid || accept) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  mer_result_reg #(
    .SQ_W  (SQ_W),
    .CNT_W (CNT_W)
  ) u_result (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .load          (close),
    .flush         (abort),
    .clear_overrun (start_go),
    .sq_i          (err_square_i),
    .sq_q          (err_square_q),
    .err_cnt       (cnt_inc),
    .win_idx       (win_q),
    .res_ready     (res_ready),
    .res_valid     (res_valid),
    .res_sq_i      (res_sq_i),
    .res_sq_q      (res_sq_q),
    .res_err_cnt   (res_err_cnt),
    .res_win_idx   (res_win_idx),
    .overrun       (overrun),
    .accept        (accept)
  );

endmodule
